// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter servo control path: op codes, scheduler
// FSM encoding and default timing constants for a 50 MHz clock.
package sorter_pkg;

    typedef enum logic [1:0] {
        OP_DISPENSE = 2'd0,
        OP_RED      = 2'd1,
        OP_GREEN    = 2'd2,
        OP_BLUE     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_SETTLE    = 2'd3
    } state_e;

    // 20 ms settle gap and 3 s stall limit at 50 MHz.
    localparam int unsigned SETTLE_TICKS_DEF  = 1000000;
    localparam int unsigned TIMEOUT_TICKS_DEF = 150000000;

    localparam int TMO_W    = 28;
    localparam int SETTLE_W = 20;

    function automatic logic is_color(op_e op);
        return op != OP_DISPENSE;
    endfunction

endpackage

// File: rtl/servo_scheduler_if.sv
// Command handshake between the scheduler (master) and the servo PWM drivers
// (slave): a one-cycle start pulse with op code, answered by a done pulse.
interface servo_scheduler_if;

    logic       cmd_start;
    logic [1:0] cmd_op;
    logic       drv_done;

    modport master (
        output cmd_start,
        output cmd_op,
        input  drv_done
    );

    modport slave (
        input  cmd_start,
        input  cmd_op,
        output drv_done
    );

endinterface

// File: rtl/sched_fifo.sv
// Synchronous command FIFO. A push into a full FIFO is still accepted when a
// pop happens in the same cycle; push_ok reports whether the push was taken.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count already define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/servo_scheduler.sv
// Queues MBED dispense/color requests and runs them one at a time on the servo
// drivers with a start/done handshake, settle gap and stall timeout.
// Define SERVO_SCHED_COUNT_EN to build the completed-dispense counter.
module servo_scheduler
    import sorter_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_TICKS  = SETTLE_TICKS_DEF,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic                      posRed,
    input  logic                      posGreen,
    input  logic                      posBlue,
    servo_scheduler_if.master         cmd_if,
    output logic                      busy,
    output logic [1:0]                cur_color,
    output logic                      fifo_full,
    output logic                      overflow_check,
    output logic                      timeout_check,
    output logic [15:0]               dispense_count
);

    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

    // Request bit index equals the op code of the command it produces.
    logic [3:0] req_s1_q, req_s1_d;
    logic [3:0] req_s2_q, req_s2_d;
    logic [3:0] req_prev_q, req_prev_d;
    logic [3:0] req_edge;

    logic       pend_q, pend_d;
    logic       overflow_q, overflow_d;
    logic       push, push_ok, pop;
    op_e        push_op;
    logic [1:0] fifo_head;
    logic       fifo_empty;

    state_e              state_q, state_d;
    op_e                 cmd_op_q, cmd_op_d;
    logic [1:0]          cur_color_q, cur_color_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                timeout_q, timeout_d;

    always_comb begin
        req_s1_d   = {posBlue, posGreen, posRed, go};
        req_s2_d   = req_s1_q;
        req_prev_d = req_s2_q;
        req_edge   = req_s2_q & ~req_prev_q;
    end

    // One push per cycle: colors win over dispense, red > green > blue.
    always_comb begin
        push       = 1'b0;
        push_op    = OP_DISPENSE;
        pend_d     = pend_q;
        overflow_d = overflow_q;

        if (req_edge[3:1] != 3'b000) begin
            push = 1'b1;
            if (req_edge[OP_RED])        push_op = OP_RED;
            else if (req_edge[OP_GREEN]) push_op = OP_GREEN;
            else                         push_op = OP_BLUE;

            if ((req_edge[OP_RED] && req_edge[OP_GREEN]) ||
                (req_edge[OP_RED] && req_edge[OP_BLUE])  ||
                (req_edge[OP_GREEN] && req_edge[OP_BLUE]))
                overflow_d = 1'b1;

            pend_d = pend_q || req_edge[OP_DISPENSE];
            if (pend_q && req_edge[OP_DISPENSE]) overflow_d = 1'b1;
        end else if (pend_q || req_edge[OP_DISPENSE]) begin
            push    = 1'b1;
            push_op = OP_DISPENSE;
            pend_d  = pend_q && req_edge[OP_DISPENSE];
        end

        if (push && !push_ok) overflow_d = 1'b1;
    end

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_op),
        .push_ok   (push_ok),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cmd_op_d     = cmd_op_q;
        cur_color_d  = cur_color_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;
        timeout_d    = timeout_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    cmd_op_d = op_e'(fifo_head);
                    // A move to the bin already selected is elided entirely.
                    if (!(is_color(op_e'(fifo_head)) && fifo_head == cur_color_q))
                        state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (cmd_if.drv_done) begin
                    if (is_color(cmd_op_q)) cur_color_d = cmd_op_q;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d    = 1'b1;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) state_d = ST_IDLE;
                else settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1_q     <= '0;
            req_s2_q     <= '0;
            req_prev_q   <= '0;
            pend_q       <= 1'b0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            cmd_op_q     <= OP_DISPENSE;
            cur_color_q  <= '0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            req_s1_q     <= req_s1_d;
            req_s2_q     <= req_s2_d;
            req_prev_q   <= req_prev_d;
            pend_q       <= pend_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            cmd_op_q     <= cmd_op_d;
            cur_color_q  <= cur_color_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef SERVO_SCHED_COUNT_EN
    logic [15:0] disp_cnt_q, disp_cnt_d;
    logic        disp_done;

    always_comb begin
        disp_done  = (state_q == ST_WAIT_DONE) && cmd_if.drv_done &&
                     (cmd_op_q == OP_DISPENSE);
        disp_cnt_d = disp_cnt_q + 16'(disp_done);
    end

    always_ff @(posedge clk) begin
        if (rst) disp_cnt_q <= '0;
        else     disp_cnt_q <= disp_cnt_d;
    end

    assign dispense_count = disp_cnt_q;
`else
    assign dispense_count = '0;
`endif

    assign cmd_if.cmd_start = (state_q == ST_ISSUE);
    assign cmd_if.cmd_op    = cmd_op_q;
    assign busy             = (state_q != ST_IDLE);
    assign cur_color        = cur_color_q;
    assign overflow_check   = overflow_q;
    assign timeout_check    = timeout_q;

endmodule

// File: tb/tb_servo_scheduler.sv
// Directed bench for servo_scheduler with shortened settle/timeout constants;
// each scenario task checks its own hand-computed expectations.
module tb_servo_scheduler;

    localparam int SETTLE = 20;
    localparam int TMO    = 200;
`ifdef SERVO_SCHED_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0, pos_red = 1'b0, pos_green = 1'b0, pos_blue = 1'b0;
    logic        busy, fifo_full, overflow_check, timeout_check;
    logic [1:0]  cur_color;
    logic [15:0] dispense_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0;
    int t_issue = 0;

    servo_scheduler_if cmd_if ();

    servo_scheduler #(
        .FIFO_DEPTH    (4),
        .SETTLE_TICKS  (SETTLE),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .posRed         (pos_red),
        .posGreen       (pos_green),
        .posBlue        (pos_blue),
        .cmd_if         (cmd_if),
        .busy           (busy),
        .cur_color      (cur_color),
        .fifo_full      (fifo_full),
        .overflow_check (overflow_check),
        .timeout_check  (timeout_check),
        .dispense_count (dispense_count)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (cmd_if.cmd_start) n_start++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_start(input int limit, output logic ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < limit) begin
            tick();
            i++;
            if (cmd_if.cmd_start) ok = 1'b1;
        end
    endtask

    task automatic pulse_done();
        cmd_if.drv_done = 1'b1;
        tick();
        cmd_if.drv_done = 1'b0;
    endtask

    task automatic pulse_req(input int op);
        case (op)
            0: go = 1'b1;
            1: pos_red = 1'b1;
            2: pos_green = 1'b1;
            default: pos_blue = 1'b1;
        endcase
        tick(2);
        go = 1'b0; pos_red = 1'b0; pos_green = 1'b0; pos_blue = 1'b0;
        tick(2);
    endtask

    task automatic check_start(input string name, input logic ok, input logic [1:0] op);
        total++;
        if (!ok || cmd_if.cmd_op !== op) begin
            bad++;
            $display("FAIL %s: started=%0b op=%0d, want started=1 op=%0d", name, ok, cmd_if.cmd_op, op);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [24:0] snap;
        snap = {cmd_if.cmd_start, cmd_if.cmd_op, busy, cur_color, fifo_full,
                overflow_check, timeout_check, dispense_count};
        total++;
        if (snap !== '0) begin
            bad++;
            $display("FAIL %s: outputs=%h want 0", name, snap);
        end
    endtask

    task automatic test_reset();
        cmd_if.drv_done = 1'b0;
        rst = 1'b1;
        tick(3);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_dispense();
        int s;
        go = 1'b1;
        tick(3);
        check_val("dispense_no_early_start", int'(cmd_if.cmd_start), 0);
        tick();
        check_start("dispense_start_latency", cmd_if.cmd_start, 2'd0);
        check_val("dispense_busy", int'(busy), 1);
        tick();
        check_val("dispense_start_single", int'(cmd_if.cmd_start), 0);
        tick(98);
        pulse_done();
        check_val("settle_busy_first", int'(busy), 1);
        tick(SETTLE - 1);
        check_val("settle_busy_last", int'(busy), 1);
        tick();
        check_val("settle_idle", int'(busy), 0);
        check_val("dispense_count_1", int'(dispense_count), CNT_EN ? 1 : 0);
        s = n_start;
        tick(10);
        check_val("held_level_one_request", n_start, s);
        go = 1'b0;
        tick(3);
    endtask

    task automatic test_elide();
        logic ok;
        logic busy_seen = 1'b0;
        int s;
        pos_green = 1'b1;
        wait_start(10, ok);
        check_start("green_start", ok, 2'd2);
        pos_green = 1'b0;
        tick(5);
        pulse_done();
        tick(SETTLE + 2);
        check_val("green_cur_color", int'(cur_color), 2);
        s = n_start;
        pos_green = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
            if (i == 3) pos_green = 1'b0;
        end
        check_val("elide_no_start", n_start, s);
        check_val("elide_cur_color", int'(cur_color), 2);
        check_val("elide_busy_low", int'(busy_seen), 0);
    endtask

    task automatic test_priority();
        logic ok;
        pos_red = 1'b1;
        go = 1'b1;
        wait_start(10, ok);
        check_start("prio_red_first", ok, 2'd1);
        tick(3);
        pos_red = 1'b0;
        go = 1'b0;
        pulse_done();
        wait_start(SETTLE + 10, ok);
        check_start("prio_dispense_second", ok, 2'd0);
        tick(3);
        pulse_done();
        tick(SETTLE + 2);
        check_val("prio_no_overflow", int'(overflow_check), 0);
        check_val("prio_cur_color", int'(cur_color), 1);
        check_val("dispense_count_2", int'(dispense_count), CNT_EN ? 2 : 0);
    endtask

    task automatic test_overflow();
        logic ok;
        go = 1'b1;
        wait_start(10, ok);
        check_start("stall_start", ok, 2'd0);
        t_issue = cyc;
        go = 1'b0;
        tick(2);
        pulse_req(2);
        pulse_req(3);
        pulse_req(1);
        pulse_req(0);
        tick(2);
        check_val("fill_full", int'(fifo_full), 1);
        check_val("fill_no_overflow", int'(overflow_check), 0);
        pulse_req(3);
        pulse_req(2);
        tick(4);
        check_val("overflow_flag", int'(overflow_check), 1);
        check_val("overflow_still_full", int'(fifo_full), 1);
    endtask

    task automatic test_timeout();
        logic ok;
        logic [1:0] exp_ops [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        int i = 0;
        while (!timeout_check && i < 2 * TMO) begin
            tick();
            i++;
        end
        check_val("timeout_flag", int'(timeout_check), 1);
        check_val("timeout_latency", cyc - t_issue, TMO + 1);
        check_val("timeout_cur_color", int'(cur_color), 1);
        check_val("timeout_settling", int'(busy), 1);
        check_val("timeout_not_counted", int'(dispense_count), CNT_EN ? 2 : 0);
        for (int k = 0; k < 4; k++) begin
            wait_start(SETTLE + 10, ok);
            check_start($sformatf("drain_order_%0d", k), ok, exp_ops[k]);
            tick(3);
            pulse_done();
        end
        tick(SETTLE + 12);
        check_val("drain_cur_color", int'(cur_color), 1);
        check_val("drain_idle", int'(busy), 0);
        check_val("drain_not_full", int'(fifo_full), 0);
        check_val("dispense_count_3", int'(dispense_count), CNT_EN ? 3 : 0);
    endtask

    task automatic test_rst_mid();
        logic ok;
        int s;
        go = 1'b1;
        wait_start(10, ok);
        check_start("rst_mid_start", ok, 2'd0);
        go = 1'b0;
        pulse_req(1);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        s = n_start;
        pulse_done();
        check_all_zero("rst_mid_outputs");
        tick(20);
        check_val("rst_mid_no_start", n_start, s);
        check_val("rst_mid_idle", int'(busy), 0);
    endtask

    initial begin
        test_reset();
        test_dispense();
        test_elide();
        test_priority();
        test_overflow();
        test_timeout();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_scheduler.md
Name: servo_scheduler

Overview:
- Sits between the MBED request lines and the two servo PWM drivers: the dispensing servo and the color-positioning servo.
- Captures request edges, queues them in order in a small FIFO, and issues one servo command at a time.
- Each command uses a start/done handshake, then a mandatory settle gap.
- Tracks the current color bin, skips redundant color moves and flags lost or stalled commands.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of 2, minimum 2.
- SETTLE_TICKS, 1000000, idle clk cycles after each command completes (20 ms at 50 MHz).
- TIMEOUT_TICKS, 150000000, maximum clk cycles waiting for drv_done (3 s).

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  MBED dispense request, asynchronous level.
- posRed  in  1  MBED select-red request, asynchronous level.
- posGreen  in  1  MBED select-green request, asynchronous level.
- posBlue  in  1  MBED select-blue request, asynchronous level.
- cmd_start  out  1  one-cycle pulse that launches a servo command.
- cmd_op  out  2  op code of the command in flight: 0 dispense, 1 red, 2 green, 3 blue.
- drv_done  in  1  one-cycle pulse from a servo driver when its move sequence finishes.
- busy  out  1  high whenever the FSM is not in IDLE.
- cur_color  out  2  last color successfully set; 0 means none.
- fifo_full  out  1  queue is full.
- overflow_check  out  1  sticky: a request was dropped.
- timeout_check  out  1  sticky: drv_done never arrived.
- dispense_count  out  16  completed dispenses (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO emptied, all synchronizers cleared, FSM to IDLE. Applies even mid-command; a drv_done arriving later is ignored.
- Inputs: each request passes a 2-FF synchronizer plus a rising-edge detector. Only edges are requests; a held-high level produces one request.
- Push latency: input first sampled high at edge 0 -> FIFO entry written at edge 2.
- Issue latency: if the FSM is IDLE at edge 3, cmd_start is high in the cycle after edge 3.
- One push per cycle. Simultaneous edges in the same cycle:
  - Color beats dispense. A color edge pushes first; a dispense edge is held in a 1-deep pend flag and pushed next cycle.
  - Among several color edges, priority is red > green > blue. Losing colors are dropped and set overflow_check.
- Full FIFO: a push while full is dropped and sets overflow_check. A push coinciding with a pop when full is accepted.
- FSM states: IDLE, ISSUE, WAIT_DONE, SETTLE.
  - IDLE: if FIFO is not empty, pop the head into cmd_op.
    - If the op is a color equal to cur_color, the command is elided: stay in IDLE, no cmd_start, nothing counted.
    - Otherwise go to ISSUE.
  - ISSUE: cmd_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE: on drv_done, go to SETTLE.
    - If the op is a color, cur_color <= cmd_op.
    - If the op is dispense, dispense_count increments.
    - If the timeout counter reaches TIMEOUT_TICKS-1 without drv_done, set timeout_check, go to SETTLE, leave cur_color unchanged.
    - If drv_done and timeout occur in the same cycle, done wins.
  - SETTLE: count SETTLE_TICKS cycles, then go to IDLE. Requests keep queuing meanwhile.
- cmd_op holds its value from ISSUE through SETTLE. In IDLE, cmd_op is the last popped value.
- drv_done outside WAIT_DONE is ignored.
- Counter widths: 28-bit timeout counter, 20-bit settle counter. dispense_count wraps 0xFFFF->0.
- Dispense order relative to color requests is strict FIFO order, so a dispense waits until all earlier color moves finish.

Optional Feature:
- Macro: SERVO_SCHED_COUNT_EN.
- Defined: the 16-bit dispense_count counter exists and behaves as above.
- Undefined: no counter logic is built; the dispense_count port remains and is tied to 0.

Decomposition:
- Shared package sorter_pkg:
  - op codes OP_DISPENSE=0, OP_RED=1, OP_GREEN=2, OP_BLUE=3;
  - FSM state encoding;
  - default tick constants (20 ms = 1000000, 3 s = 150000000 at 50 MHz).
- Sub-module sched_fifo:
  - synchronous FIFO, width 2, depth FIFO_DEPTH;
  - push/pop/full/empty; push accepted on simultaneous pop when full.

Test Plan:
- go rising, FSM idle -> cmd_start single pulse with cmd_op=0 in the cycle after edge 3. drv_done after 100 cycles -> busy stays high 1000000 more cycles, dispense_count=1.
- posGreen pulse, drv_done returned -> cur_color=2. Second posGreen -> no cmd_start, cur_color remains 2, busy remains 0.
- posRed and go rising in the same cycle -> first command cmd_op=1. After its done and settle -> cmd_op=0. overflow_check=0.
- FIFO_DEPTH=4, command stalled in WAIT_DONE, 6 distinct request edges -> 4 queued, overflow_check=1, fifo_full=1. Commands then issue in arrival order.
- cmd_start issued, no drv_done -> after TIMEOUT_TICKS cycles timeout_check=1, then SETTLE, then next queued command issues. cur_color unchanged.
- rst asserted in WAIT_DONE, then drv_done pulses -> all outputs 0, FIFO empty, no cmd_start follows.
